// File: rtl/datapath_storage.sv
// Storage elements of a 16-bit datapath: instruction memory, 8-entry
// register file and data memory.
// Instruction memory holds its contents through reset and starts at zero.
// The register file and data memory clear asynchronously while reset is high.
// Optional feature macro: REGFILE_BYPASS_EN forwards the register write
// data to a matching read port in the same cycle.
module datapath_storage #(
    parameter int IMEM_AW = 8,
    parameter int DMEM_AW = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pc,
    output logic [15:0] instr,
    input  logic        imem_we,
    input  logic [15:0] imem_waddr,
    input  logic [15:0] imem_wdata,
    input  logic [2:0]  rs,
    input  logic [2:0]  rt,
    input  logic [2:0]  rd,
    input  logic [15:0] wd,
    input  logic        rf_we,
    output logic [15:0] rd1,
    output logic [15:0] rd2,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    input  logic        mem_write,
    input  logic        mem_read,
    output logic [15:0] dm_rdata
);

    localparam int IMEM_WORDS = 1 << IMEM_AW;
    localparam int DMEM_WORDS = 1 << DMEM_AW;

    // The declaration initialiser gives the power-up contents; reset never touches this array.
    logic [15:0] imem [IMEM_WORDS] = '{default: 16'h0000};
    logic [15:0] regs [8];
    logic [15:0] dmem [DMEM_WORDS];

    logic [IMEM_AW-1:0] imem_rd_idx;
    logic [IMEM_AW-1:0] imem_wr_idx;
    logic [DMEM_AW-1:0] dmem_idx;

    // Upper address bits are dropped by design, so the memories wrap.
    logic unused_addr_bits;

    assign imem_rd_idx = pc[IMEM_AW-1:0];
    assign imem_wr_idx = imem_waddr[IMEM_AW-1:0];
    assign dmem_idx    = dm_addr[DMEM_AW-1:0];

    assign unused_addr_bits = ^{pc[15:IMEM_AW], imem_waddr[15:IMEM_AW], dm_addr[15:DMEM_AW]};

    // Program load: instruction memory stays writable even while reset is asserted.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[imem_wr_idx] <= imem_wdata;
        end
    end

    assign instr = imem[imem_rd_idx];

    // Register file: cleared asynchronously by reset, otherwise written on the clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= 16'h0000;
            end
        end else if (rf_we) begin
            regs[rd] <= wd;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forward the pending write to a matching read port; suppressed during reset because the write is discarded.
    always_comb begin
        rd1 = regs[rs];
        rd2 = regs[rt];
        if (rf_we && !reset && (rd == rs)) begin
            rd1 = wd;
        end
        if (rf_we && !reset && (rd == rt)) begin
            rd2 = wd;
        end
    end
`else
    // Plain reads return the stored value; a write in this cycle shows up after the edge.
    always_comb begin
        rd1 = regs[rs];
        rd2 = regs[rt];
    end
`endif

    // Data memory: cleared asynchronously by reset, otherwise written on the clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DMEM_WORDS; i++) begin
                dmem[i] <= 16'h0000;
            end
        end else if (mem_write) begin
            dmem[dmem_idx] <= dm_wdata;
        end
    end

    // The read port is gated so an idle read drives zero onto the bus.
    always_comb begin
        dm_rdata = 16'h0000;
        if (mem_read) begin
            dm_rdata = dmem[dmem_idx];
        end
    end

endmodule

// File: tb/tb_datapath_storage.sv
// Self-checking bench for datapath_storage using random stimulus and a
// behavioural model of the three storage arrays.
module tb_datapath_storage;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc;
    logic [15:0] instr;
    logic        imem_we;
    logic [15:0] imem_waddr;
    logic [15:0] imem_wdata;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  rd;
    logic [15:0] wd;
    logic        rf_we;
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [15:0] dm_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: plain arrays indexed modulo their size.
    logic [15:0] m_imem [256];
    logic [15:0] m_rf   [8];
    logic [15:0] m_dmem [64];

    datapath_storage dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .instr      (instr),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .wd         (wd),
        .rf_we      (rf_we),
        .rd1        (rd1),
        .rd2        (rd2),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .dm_rdata   (dm_rdata)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_read(input logic [2:0] a);
`ifdef REGFILE_BYPASS_EN
        if (rf_we && !reset && (rd == a)) return wd;
`endif
        return m_rf[a];
    endfunction

    task automatic test_reset();
        reset = 1'b1; imem_we = 0; rf_we = 0; mem_write = 0; mem_read = 1;
        pc = 16'h0000; imem_waddr = 0; imem_wdata = 0; rs = 0; rt = 7; rd = 0;
        wd = 0; dm_addr = 0; dm_wdata = 0;
        for (int i = 0; i < 256; i++) m_imem[i] = 16'h0000;
        for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
        for (int i = 0; i < 64; i++) m_dmem[i] = 16'h0000;
        tick();
        n_checks++;
        if (rd1 !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_rd1 got %h want 0000", rd1); end
        n_checks++;
        if (rd2 !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_rd2 got %h want 0000", rd2); end
        n_checks++;
        if (dm_rdata !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_dm got %h want 0000", dm_rdata); end
        pc = 16'h0033; #1;
        n_checks++;
        if (instr !== 16'h0000) begin n_fail++; $display("[TB] FAIL powerup_imem got %h want 0000", instr); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_program_load();
        logic [15:0] a;
        logic [15:0] d;
        imem_we = 1; imem_waddr = 16'd5; imem_wdata = 16'h4A21;
        tick();
        m_imem[5] = 16'h4A21;
        imem_we = 0;
        pc = 16'd5; #1;
        n_checks++;
        if (instr !== 16'h4A21) begin n_fail++; $display("[TB] FAIL imem_pc5 got %h want 4a21", instr); end
        pc = 16'h0105; #1;
        n_checks++;
        if (instr !== 16'h4A21) begin n_fail++; $display("[TB] FAIL imem_wrap got %h want 4a21", instr); end
        for (int k = 0; k < 24; k++) begin
            a = 16'($urandom); d = 16'($urandom);
            if ((a % 256) == 5) a = a + 1;
            imem_we = 1; imem_waddr = a; imem_wdata = d;
            tick();
            m_imem[a % 256] = d;
            imem_we = 0;
            pc = 16'($urandom); #1;
            n_checks++;
            if (instr !== m_imem[pc % 256]) begin
                n_fail++; $display("[TB] FAIL imem_rand pc=%h got %h want %h", pc, instr, m_imem[pc % 256]);
            end
        end
    endtask

    task automatic test_regfile();
        rf_we = 1; rd = 3; wd = 16'hBEEF;
        tick();
        m_rf[3] = 16'hBEEF;
        rf_we = 0; wd = 16'h1234; rs = 3; rt = 3;
        tick();
        n_checks++;
        if (rd1 !== 16'hBEEF) begin n_fail++; $display("[TB] FAIL rf_r3_rd1 got %h want beef", rd1); end
        n_checks++;
        if (rd2 !== 16'hBEEF) begin n_fail++; $display("[TB] FAIL rf_r3_rd2 got %h want beef", rd2); end
        for (int k = 0; k < 40; k++) begin
            rf_we = 1'($urandom); rd = 3'($urandom); wd = 16'($urandom);
            rs = 3'($urandom); rt = 3'($urandom);
            if (rd == 3) rf_we = 0;
            #1;
            n_checks++;
            if (rd1 !== exp_read(rs)) begin
                n_fail++; $display("[TB] FAIL rf_rand_rd1 rs=%0d got %h want %h", rs, rd1, exp_read(rs));
            end
            n_checks++;
            if (rd2 !== exp_read(rt)) begin
                n_fail++; $display("[TB] FAIL rf_rand_rd2 rt=%0d got %h want %h", rt, rd2, exp_read(rt));
            end
            tick();
            if (rf_we) m_rf[rd] = wd;
        end
        rf_we = 0;
    endtask

    task automatic test_read_during_write();
        logic [15:0] old;
        old = m_rf[2];
        rs = 2; rd = 2; wd = (old == 16'h5555) ? 16'hAAAA : 16'h5555; rf_we = 1;
        #1;
        n_checks++;
`ifdef REGFILE_BYPASS_EN
        if (rd1 !== wd) begin n_fail++; $display("[TB] FAIL rdw_bypass got %h want %h", rd1, wd); end
`else
        if (rd1 !== old) begin n_fail++; $display("[TB] FAIL rdw_old got %h want %h", rd1, old); end
`endif
        tick();
        m_rf[2] = wd;
        rf_we = 0; #1;
        n_checks++;
        if (rd1 !== m_rf[2]) begin n_fail++; $display("[TB] FAIL rdw_after got %h want %h", rd1, m_rf[2]); end
    endtask

    task automatic test_dmem();
        mem_write = 1; dm_addr = 16'd10; dm_wdata = 16'h00FF; mem_read = 0;
        tick();
        m_dmem[10] = 16'h00FF;
        mem_write = 0; mem_read = 1; #1;
        n_checks++;
        if (dm_rdata !== 16'h00FF) begin n_fail++; $display("[TB] FAIL dm_a10 got %h want 00ff", dm_rdata); end
        mem_read = 0; #1;
        n_checks++;
        if (dm_rdata !== 16'h0000) begin n_fail++; $display("[TB] FAIL dm_noread got %h want 0000", dm_rdata); end
        mem_read = 1; dm_addr = 16'd74; #1;
        n_checks++;
        if (dm_rdata !== 16'h00FF) begin n_fail++; $display("[TB] FAIL dm_alias got %h want 00ff", dm_rdata); end
        for (int k = 0; k < 40; k++) begin
            mem_write = 1'($urandom); dm_addr = 16'($urandom); dm_wdata = 16'($urandom);
            mem_read = 1'($urandom);
            if ((dm_addr % 64) == 10) mem_write = 0;
            #1;
            n_checks++;
            if (dm_rdata !== (mem_read ? m_dmem[dm_addr % 64] : 16'h0000)) begin
                n_fail++; $display("[TB] FAIL dm_rand addr=%h got %h want %h", dm_addr, dm_rdata,
                                   mem_read ? m_dmem[dm_addr % 64] : 16'h0000);
            end
            tick();
            if (mem_write) m_dmem[dm_addr % 64] = dm_wdata;
        end
        mem_write = 0;
    endtask

    task automatic test_dmem_same_addr_rw();
        logic [15:0] old;
        dm_addr = 16'd20; old = m_dmem[20];
        dm_wdata = ~old; mem_write = 1; mem_read = 1; #1;
        n_checks++;
        if (dm_rdata !== old) begin n_fail++; $display("[TB] FAIL dm_rw_before got %h want %h", dm_rdata, old); end
        tick();
        m_dmem[20] = ~old;
        mem_write = 0; #1;
        n_checks++;
        if (dm_rdata !== m_dmem[20]) begin n_fail++; $display("[TB] FAIL dm_rw_after got %h want %h", dm_rdata, m_dmem[20]); end
    endtask

    task automatic test_async_reset();
        rf_we = 1; rd = 3; wd = 16'hBEEF; mem_write = 1; dm_addr = 16'd10; dm_wdata = 16'h00FF;
        tick();
        m_rf[3] = 16'hBEEF; m_dmem[10] = 16'h00FF;
        rf_we = 0; mem_write = 0; rs = 3; mem_read = 1; pc = 16'd5; #1;
        n_checks++;
        if (rd1 !== 16'hBEEF) begin n_fail++; $display("[TB] FAIL ar_pre_rd1 got %h want beef", rd1); end
        reset = 1; #1;
        for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
        for (int i = 0; i < 64; i++) m_dmem[i] = 16'h0000;
        n_checks++;
        if (rd1 !== 16'h0000) begin n_fail++; $display("[TB] FAIL ar_rd1 got %h want 0000", rd1); end
        n_checks++;
        if (dm_rdata !== 16'h0000) begin n_fail++; $display("[TB] FAIL ar_dm got %h want 0000", dm_rdata); end
        n_checks++;
        if (instr !== m_imem[5]) begin n_fail++; $display("[TB] FAIL ar_imem got %h want %h", instr, m_imem[5]); end
        reset = 0;
        tick();
    endtask

    task automatic test_reset_precedence();
        reset = 1; rf_we = 1; rd = 4; wd = 16'hCAFE; mem_write = 1; dm_addr = 16'd7;
        dm_wdata = 16'hF00D; imem_we = 1; imem_waddr = 16'd200; imem_wdata = 16'h7E57;
        tick();
        m_imem[200] = 16'h7E57;
        rf_we = 0; mem_write = 0; imem_we = 0;
        reset = 0; #1;
        rs = 4; mem_read = 1; pc = 16'd200; #1;
        n_checks++;
        if (rd1 !== m_rf[4]) begin n_fail++; $display("[TB] FAIL rp_rf got %h want %h", rd1, m_rf[4]); end
        n_checks++;
        if (dm_rdata !== m_dmem[7]) begin n_fail++; $display("[TB] FAIL rp_dm got %h want %h", dm_rdata, m_dmem[7]); end
        n_checks++;
        if (instr !== m_imem[200]) begin n_fail++; $display("[TB] FAIL rp_imem got %h want %h", instr, m_imem[200]); end
        tick();
    endtask

    initial begin
        test_reset();
        test_program_load();
        test_regfile();
        test_read_during_write();
        test_dmem();
        test_dmem_same_addr_rw();
        test_async_reset();
        test_reset_precedence();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/datapath_storage.md
DATAPATH_STORAGE -- requirements
Module: datapath_storage

Interface
REQ-001 Parameter IMEM_AW, default 8: instruction memory word-address width, giving 256 x 16-bit words.
REQ-002 Parameter DMEM_AW, default 6: data memory word-address width, giving 64 x 16-bit words.
REQ-003 clk  input  1  single system clock; all writes occur on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 pc  input  16  instruction fetch word address.
REQ-006 instr  output  16  instruction word at pc.
REQ-007 imem_we  input  1  program-load write enable for instruction memory.
REQ-008 imem_waddr  input  16  program-load word address.
REQ-009 imem_wdata  input  16  program-load data.
REQ-010 rs  input  3  register file read address for port 1.
REQ-011 rt  input  3  register file read address for port 2.
REQ-012 rd  input  3  register file write address.
REQ-013 wd  input  16  register file write data.
REQ-014 rf_we  input  1  register file write enable.
REQ-015 rd1  output  16  register file port-1 read data.
REQ-016 rd2  output  16  register file port-2 read data.
REQ-017 dm_addr  input  16  data memory word address.
REQ-018 dm_wdata  input  16  data memory write data.
REQ-019 mem_write  input  1  data memory write enable.
REQ-020 mem_read  input  1  data memory read enable.
REQ-021 dm_rdata  output  16  data memory read data.

Function
REQ-022 Instruction memory: instr SHALL equal imem[pc[IMEM_AW-1:0]] combinationally, so pc bits above IMEM_AW are ignored and addresses wrap.
REQ-023 Instruction memory write: on a rising edge with imem_we=1, imem[imem_waddr[IMEM_AW-1:0]] SHALL take imem_wdata; instr reflects the new value after that edge.
REQ-024 Register file: 8 x 16-bit registers; rd1 = R[rs] and rd2 = R[rt], both combinational.
REQ-025 Register file write: on a rising edge with rf_we=1, R[rd] SHALL take wd; with rf_we=0 no register changes.
REQ-026 Register file read-during-write: a read of address rd in the write cycle SHALL return the old value; the new value appears after the edge (subject to REQ-034).
REQ-027 Data memory write: on a rising edge with mem_write=1, dmem[dm_addr[DMEM_AW-1:0]] SHALL take dm_wdata; upper address bits are ignored.
REQ-028 Data memory read: dm_rdata = dmem[dm_addr[DMEM_AW-1:0]] combinationally when mem_read=1, and 16'h0000 when mem_read=0.
REQ-029 Data memory simultaneous read and write to the same address: dm_rdata SHALL show the old word until the edge and the new word after it.
REQ-030 All arithmetic and width rules: addresses truncate, with no error flag; data is stored unmodified.

Reset
REQ-031 While reset=1, all 8 registers and all data memory words SHALL be cleared to 0 immediately (asynchronously), so rd1, rd2 and dm_rdata (if mem_read=1) read 0.
REQ-032 Instruction memory contents SHALL be unaffected by reset and SHALL be 0 at power-up.
REQ-033 While reset=1, register file and data memory writes SHALL be ignored; instruction memory writes remain permitted; normal operation resumes on the first rising edge after deassertion.

Configuration
REQ-034 Macro REGFILE_BYPASS_EN: when defined, if rf_we=1 and rd equals rs (or rt), rd1 (or rd2) SHALL return wd combinationally in that cycle; when undefined, REQ-026 holds.

Verification
REQ-035 Program load: write imem[5]=16'h4A21 via imem_we, then set pc=5 -> instr=16'h4A21; pc=16'h0105 -> also 16'h4A21 (wrap).
REQ-036 Register write/read: rf_we=1, rd=3, wd=16'hBEEF on an edge; then rs=3, rt=3 -> rd1=rd2=16'hBEEF; rf_we=0 with wd=16'h1234 -> R3 unchanged.
REQ-037 Data memory: mem_write=1, dm_addr=10, dm_wdata=16'h00FF, then mem_read=1 -> dm_rdata=16'h00FF; mem_read=0 -> dm_rdata=0; dm_addr=74 -> 16'h00FF (aliasing with DMEM_AW=6).
REQ-038 Async reset: with R3=16'hBEEF and dmem[10]=16'h00FF, pulse reset between clock edges -> rd1 and dm_rdata read 0 immediately; imem[5] still 16'h4A21.
REQ-039 Read-during-write: rs=rd=2, wd=16'h5555, rf_we=1 -> before the edge rd1=old value without REGFILE_BYPASS_EN, and 16'h5555 with it.
REQ-040 Reset precedence: reset=1 with rf_we=1 and mem_write=1 held across an edge -> no register or memory change.
